tcm_dualport_mem: RTL and testbench

Tightly-coupled single-cycle memory for the riscv_core. It has a 64-bit instruction-fetch port and a 32-bit tagged data load/store port, both backed by one true dual-port byte array. It has no caches, so cache maintenance requests are acknowledged but have no effect. A simulation backdoor byte-write task is used for program loading.

---
 rtl/tcm_dualport_mem.sv | 116 +++++++++++
 tb/tb_tcm_dualport_mem.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tcm_dualport_mem.sv
// Single-cycle tightly-coupled memory: 64-bit fetch port plus 32-bit tagged load/store port
// sharing one byte array. Cache maintenance requests are acknowledged but do nothing.
module tcm_dualport_mem #(
  parameter int TCM_RAM_SIZE = 49152,
  parameter int TCM_ROM_SIZE = 16384
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        mem_i_rd_i,
  input  logic        mem_i_flush_i,
  input  logic        mem_i_invalidate_i,
  input  logic [31:0] mem_i_pc_i,
  output logic        mem_i_accept_o,
  output logic        mem_i_valid_o,
  output logic        mem_i_error_o,
  output logic [63:0] mem_i_inst_o,

  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam int MEM_SIZE = TCM_RAM_SIZE + TCM_ROM_SIZE;
  localparam int AW       = $clog2(MEM_SIZE);

  logic [7:0]    mem [MEM_SIZE];

  logic [AW-1:0] fetch_base;
  logic [AW-1:0] data_base;
  logic [63:0]   fetch_dw;
  logic [31:0]   data_word;
  logic          data_req;
  logic          data_access;

  assign mem_i_accept_o = 1'b1;
  assign mem_i_error_o  = 1'b0;
  assign mem_d_accept_o = 1'b1;
  assign mem_d_error_o  = 1'b0;

  // Upper address bits are dropped so out-of-range accesses alias into the array.
  assign fetch_base = {mem_i_pc_i[AW-1:3], 3'b000};
  assign data_base  = {mem_d_addr_i[AW-1:2], 2'b00};

  assign data_access = mem_d_rd_i | (|mem_d_wr_i);
  assign data_req    = data_access | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;

  always_comb begin
    fetch_dw  = '0;
    data_word = '0;
    for (int k = 0; k < 8; k++) begin
      fetch_dw[8*k +: 8] = mem[fetch_base + AW'(k)];
    end
    for (int k = 0; k < 4; k++) begin
      data_word[8*k +: 8] = mem[data_base + AW'(k)];
    end
  end

  // Array has no reset so contents survive rst_i; the backdoor task shares this storage.
  always @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_d_wr_i[k]) begin
        mem[data_base + AW'(k)] <= mem_d_data_wr_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_i_valid_o <= 1'b0;
      mem_i_inst_o  <= '0;
    end else begin
      mem_i_valid_o <= mem_i_rd_i;
      if (mem_i_rd_i) begin
        mem_i_inst_o <= fetch_dw;
      end
    end
  end

  // Load data is sampled before the store lands, giving read-before-write on mixed requests.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_d_ack_o      <= 1'b0;
      mem_d_data_rd_o  <= '0;
      mem_d_resp_tag_o <= '0;
    end else begin
      mem_d_ack_o <= data_req;
      if (data_req) begin
        mem_d_resp_tag_o <= mem_d_req_tag_i;
      end
      if (data_access) begin
        mem_d_data_rd_o <= data_word;
      end
    end
  end

  logic unused;
  assign unused = &{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                    mem_i_pc_i, mem_d_addr_i};

  task automatic write(input logic [31:0] addr, input logic [7:0] data);
    mem[addr[AW-1:0]] <= data;
  endtask

endmodule

// File: tb/tb_tcm_dualport_mem.sv
// Directed bench for tcm_dualport_mem: fetch, tagged load/store, strobes, wrap,
// same-cycle fetch/store collision and asynchronous reset.
module tb_tcm_dualport_mem;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_i_rd_i = 1'b0;
  logic        mem_i_flush_i = 1'b0;
  logic        mem_i_invalidate_i = 1'b0;
  logic [31:0] mem_i_pc_i = '0;
  logic        mem_i_accept_o;
  logic        mem_i_valid_o;
  logic        mem_i_error_o;
  logic [63:0] mem_i_inst_o;
  logic [31:0] mem_d_addr_i = '0;
  logic [31:0] mem_d_data_wr_i = '0;
  logic        mem_d_rd_i = 1'b0;
  logic [3:0]  mem_d_wr_i = '0;
  logic        mem_d_cacheable_i = 1'b0;
  logic [10:0] mem_d_req_tag_i = '0;
  logic        mem_d_invalidate_i = 1'b0;
  logic        mem_d_writeback_i = 1'b0;
  logic        mem_d_flush_i = 1'b0;
  logic [31:0] mem_d_data_rd_o;
  logic        mem_d_accept_o;
  logic        mem_d_ack_o;
  logic        mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;

  int n_checks = 0;
  int n_fail   = 0;

  tcm_dualport_mem dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
    .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
    .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
    .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
    .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_flush_i(mem_d_flush_i), .mem_d_data_rd_o(mem_d_data_rd_o),
    .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
    .mem_d_error_o(mem_d_error_o), .mem_d_resp_tag_o(mem_d_resp_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic d_idle();
    mem_d_rd_i = 1'b0; mem_d_wr_i = 4'b0000;
    mem_d_flush_i = 1'b0; mem_d_invalidate_i = 1'b0; mem_d_writeback_i = 1'b0;
  endtask

  initial begin
    #2 rst_i = 1'b0;
    #1;
    chk("rst_i_valid", 64'(mem_i_valid_o), 64'h0);
    chk("rst_i_inst", mem_i_inst_o, 64'h0);
    chk("rst_d_ack", 64'(mem_d_ack_o), 64'h0);
    chk("rst_d_data", 64'(mem_d_data_rd_o), 64'h0);
    chk("rst_d_tag", 64'(mem_d_resp_tag_o), 64'h0);
    chk("accepts", 64'({mem_i_accept_o, mem_d_accept_o}), 64'h3);

    // Program load through the backdoor while reset is held
    dut.write(32'h0, 8'h13); dut.write(32'h1, 8'h00);
    dut.write(32'h2, 8'h00); dut.write(32'h3, 8'h00);
    dut.write(32'h4, 8'h93); dut.write(32'h5, 8'h00);
    dut.write(32'h6, 8'h10); dut.write(32'h7, 8'h00);
    for (int i = 0; i < 8; i++) dut.write(32'h8 + 32'(i), 8'hA0 + 8'(i));
    dut.write(32'h10, 8'h01); dut.write(32'h11, 8'h02);
    dut.write(32'h12, 8'h03); dut.write(32'h13, 8'h04);
    dut.write(32'h14, 8'h55); dut.write(32'h15, 8'h66);
    dut.write(32'h16, 8'h77); dut.write(32'h17, 8'h88);
    step();
    rst_i = 1'b1;
    step();

    mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h4; mem_i_flush_i = 1'b1;
    step();
    chk("fetch_valid", 64'(mem_i_valid_o), 64'h1);
    chk("fetch_inst", mem_i_inst_o, 64'h00100093_00000013);
    chk("fetch_err", 64'(mem_i_error_o), 64'h0);

    mem_i_rd_i = 1'b0; mem_i_flush_i = 1'b0; mem_i_pc_i = 32'h8;
    step();
    chk("fetch_idle_valid", 64'(mem_i_valid_o), 64'h0);
    chk("fetch_idle_hold", mem_i_inst_o, 64'h00100093_00000013);

    // Back-to-back fetches
    mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h0;
    step();
    chk("b2b_fetch0", mem_i_inst_o, 64'h00100093_00000013);
    mem_i_pc_i = 32'hD;
    step();
    chk("b2b_fetch1", mem_i_inst_o, 64'hA7A6A5A4_A3A2A1A0);
    chk("b2b_fetch1_valid", 64'(mem_i_valid_o), 64'h1);
    mem_i_rd_i = 1'b0;

    mem_d_addr_i = 32'h8000; mem_d_wr_i = 4'b1111;
    mem_d_data_wr_i = 32'hDEADBEEF; mem_d_req_tag_i = 11'h155;
    step();
    chk("store_ack", 64'(mem_d_ack_o), 64'h1);
    chk("store_tag", 64'(mem_d_resp_tag_o), 64'h155);

    mem_d_wr_i = 4'b0000; mem_d_rd_i = 1'b1; mem_d_req_tag_i = 11'h2AA;
    step();
    chk("load_ack", 64'(mem_d_ack_o), 64'h1);
    chk("load_data", 64'(mem_d_data_rd_o), 64'hDEADBEEF);
    chk("load_tag", 64'(mem_d_resp_tag_o), 64'h2AA);

    d_idle(); mem_d_req_tag_i = 11'h7FF;
    step();
    chk("idle_ack", 64'(mem_d_ack_o), 64'h0);
    chk("idle_data_hold", 64'(mem_d_data_rd_o), 64'hDEADBEEF);
    chk("idle_tag_hold", 64'(mem_d_resp_tag_o), 64'h2AA);

    // Byte-strobe store returns the pre-write word
    mem_d_wr_i = 4'b0100; mem_d_data_wr_i = 32'h00AA0000; mem_d_req_tag_i = 11'h001;
    step();
    chk("strobe_ack", 64'(mem_d_ack_o), 64'h1);
    chk("strobe_rbw", 64'(mem_d_data_rd_o), 64'hDEADBEEF);
    mem_d_wr_i = 4'b0000; mem_d_rd_i = 1'b1; mem_d_req_tag_i = 11'h002;
    step();
    chk("strobe_load", 64'(mem_d_data_rd_o), 64'hDEAABEEF);

    mem_d_addr_i = 32'h0001_8000; mem_d_req_tag_i = 11'h003;
    step();
    chk("wrap_load", 64'(mem_d_data_rd_o), 64'hDEAABEEF);
    chk("wrap_err", 64'(mem_d_error_o), 64'h0);
    mem_d_addr_i = 32'h8003;
    step();
    chk("unaligned_load", 64'(mem_d_data_rd_o), 64'hDEAABEEF);

    // Maintenance op: ack and tag only, memory untouched
    d_idle(); mem_d_flush_i = 1'b1; mem_d_addr_i = 32'h8000;
    mem_d_data_wr_i = 32'h0; mem_d_req_tag_i = 11'h404;
    step();
    chk("flush_ack", 64'(mem_d_ack_o), 64'h1);
    chk("flush_tag", 64'(mem_d_resp_tag_o), 64'h404);

    // Read plus write: store with read-before-write
    d_idle(); mem_d_rd_i = 1'b1; mem_d_wr_i = 4'b0001;
    mem_d_data_wr_i = 32'h00000077; mem_d_req_tag_i = 11'h005;
    step();
    chk("rdwr_rbw", 64'(mem_d_data_rd_o), 64'hDEAABEEF);
    mem_d_wr_i = 4'b0000; mem_d_req_tag_i = 11'h006;
    step();
    chk("rdwr_after", 64'(mem_d_data_rd_o), 64'hDEAABE77);
    chk("rdwr_tag", 64'(mem_d_resp_tag_o), 64'h006);

    // Same-cycle fetch and store to 0x10
    d_idle(); mem_d_wr_i = 4'b1111; mem_d_addr_i = 32'h10;
    mem_d_data_wr_i = 32'h11223344; mem_d_req_tag_i = 11'h007;
    mem_i_rd_i = 1'b1; mem_i_pc_i = 32'h10;
    step();
    chk("collide_fetch_old", mem_i_inst_o, 64'h88776655_04030201);
    d_idle(); mem_i_pc_i = 32'h17;
    step();
    chk("collide_fetch_new", mem_i_inst_o, 64'h88776655_11223344);

    // Async reset in the middle of back-to-back loads and fetches
    mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h8000; mem_d_req_tag_i = 11'h008;
    mem_i_pc_i = 32'h0;
    step();
    chk("pre_rst_ack", 64'(mem_d_ack_o), 64'h1);
    mem_d_req_tag_i = 11'h009;
    step();
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_ack", 64'(mem_d_ack_o), 64'h0);
    chk("midrst_valid", 64'(mem_i_valid_o), 64'h0);
    chk("midrst_data", 64'(mem_d_data_rd_o), 64'h0);
    chk("midrst_tag", 64'(mem_d_resp_tag_o), 64'h0);
    chk("midrst_inst", mem_i_inst_o, 64'h0);
    #1 rst_i = 1'b1;
    mem_d_req_tag_i = 11'h00A; mem_i_pc_i = 32'h10;
    step();
    chk("post_rst_data", 64'(mem_d_data_rd_o), 64'hDEAABE77);
    chk("post_rst_tag", 64'(mem_d_resp_tag_o), 64'h00A);
    chk("post_rst_inst", mem_i_inst_o, 64'h88776655_11223344);

    d_idle(); mem_i_rd_i = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
